// File: rtl/timer_array.sv
// ---------------------------------------------------------------------------
// timer_array
//
// Multi-channel programmable timer for the MIPS system bus. It occupies one
// device slot behind the bridge. Each of the NUM_CH channels is an
// independent down-counter that runs in one of three modes:
//   00 one-shot, 01 periodic, 10 square wave (11 behaves like 00).
// The channels share one write-1-to-clear pending register. Each channel's
// pending bit is masked by its IM bit to form the interrupt fed to HWInt.
//
// Register map (word address: upper bits = channel, low 2 bits = register)
//   0 CTRL   : [0] EN, [2:1] MODE, [3] IM; all other bits read 0
//   1 PRESET : WIDTH-bit reload value (0 behaves as 1)
//   2 COUNT  : current count, read-only
//   3 STATUS : global pending[NUM_CH-1:0]; writing 1 to bit i clears bit i
//
// Parameters
//   NUM_CH   : number of channels, power of two, 2..8
//   WIDTH    : counter/preset width, 8..32; reads zero-extend to 32 bits
//   PRESCALE : tick divider, >= 2; used only with TIMER_PRESCALE_EN
//
// Configuration macro
//   TIMER_PRESCALE_EN : when defined, a shared free-running divider produces
//                       a one-cycle tick every PRESCALE clocks. COUNT
//                       decrements and reloads only on that tick. When the
//                       macro is undefined, the tick is always active.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   addr     in   word address
//   we       in   write strobe, sampled on the rising edge of clk
//   datain   in   write data
//   dataout  out  combinational read data for addr
//   irq      out  per-channel interrupt (pending & IM)
//   irq_any  out  OR of irq
//   tout     out  per-channel square-wave output
// ---------------------------------------------------------------------------
module timer_array #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NUM_CH)+1:0]  addr,
  input  logic                       we,
  input  logic [31:0]                datain,
  output logic [31:0]                dataout,
  output logic [NUM_CH-1:0]          irq,
  output logic                       irq_any,
  output logic [NUM_CH-1:0]          tout
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = CW + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;

  // -------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------
  logic tick;

`ifdef TIMER_PRESCALE_EN
  localparam int DW = $clog2(PRESCALE);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // The divider runs freely and is shared by all channels.
  always_comb begin
    div_d = div_q + DW'(1);
    if (div_q == DW'(PRESCALE - 1)) begin
      div_d = '0;
    end
  end

  assign tick = (div_q == DW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  localparam int unused_prescale = PRESCALE;

  assign tick = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Channel state
  // -------------------------------------------------------------------------
  logic [1:0]       state_q  [NUM_CH];
  logic [1:0]       state_d  [NUM_CH];
  logic [WIDTH-1:0] count_q  [NUM_CH];
  logic [WIDTH-1:0] count_d  [NUM_CH];
  logic [WIDTH-1:0] preset_q [NUM_CH];
  logic [WIDTH-1:0] preset_d [NUM_CH];
  logic [1:0]       mode_q   [NUM_CH];
  logic [1:0]       mode_d   [NUM_CH];

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] en_d;
  logic [NUM_CH-1:0] im_q;
  logic [NUM_CH-1:0] im_d;
  logic [NUM_CH-1:0] tout_q;
  logic [NUM_CH-1:0] tout_d;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [CW-1:0]     addr_ch;
  logic [1:0]        addr_reg;
  logic              ch_valid;
  logic [NUM_CH-1:0] ctrl_wr;
  logic [NUM_CH-1:0] preset_wr;
  logic              status_wr;
  logic [NUM_CH-1:0] status_clr;
  logic [WIDTH-1:0]  reload_val [NUM_CH];

  assign addr_ch  = addr[AW-1:2];
  assign addr_reg = addr[1:0];

  // Always true for power-of-two NUM_CH. It guards the decode in case a
  // non-power-of-two channel count is ever allowed.
  assign ch_valid = (int'(addr_ch) < NUM_CH);

  assign status_wr  = we && ch_valid && (addr_reg == REG_STATUS);
  assign status_clr = status_wr ? datain[NUM_CH-1:0] : '0;

  // A preset of zero reloads as one, so the channel expires on the next tick
  // instead of wrapping around.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_wr[i]    = we && ch_valid && (addr_reg == REG_CTRL)
                      && (addr_ch == CW'(i));
      preset_wr[i]  = we && ch_valid && (addr_reg == REG_PRESET)
                      && (addr_ch == CW'(i));
      reload_val[i] = (preset_q[i] == '0) ? WIDTH'(1) : preset_q[i];
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel next state
  // -------------------------------------------------------------------------
  // A CTRL write takes priority over the FSM step in that cycle. With EN=1 it
  // restarts the channel through LOAD. With EN=0 it parks the channel in IDLE.
  // In both cases COUNT and tout keep their values on that edge.
  // Hardware sets of pending win over a coincident STATUS clear.
  logic [NUM_CH-1:0] pend_set;

  always_comb begin
    pend_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      preset_d[i] = preset_q[i];
      mode_d[i]   = mode_q[i];
      en_d[i]     = en_q[i];
      im_d[i]     = im_q[i];
      tout_d[i]   = tout_q[i];

      if (ctrl_wr[i]) begin
        en_d[i]    = datain[0];
        mode_d[i]  = datain[2:1];
        im_d[i]    = datain[3];
        state_d[i] = datain[0] ? ST_LOAD : ST_IDLE;
      end else begin
        case (state_q[i])
          ST_LOAD: begin
            count_d[i] = reload_val[i];
            state_d[i] = ST_COUNT;
          end
          ST_COUNT: begin
            if (tick) begin
              if (count_q[i] > WIDTH'(1)) begin
                count_d[i] = count_q[i] - WIDTH'(1);
              end else begin
                case (mode_q[i])
                  MODE_PERIODIC: begin
                    count_d[i]  = reload_val[i];
                    pend_set[i] = 1'b1;
                  end
                  MODE_SQUARE: begin
                    count_d[i] = reload_val[i];
                    tout_d[i]  = ~tout_q[i];
                  end
                  default: begin
                    count_d[i]  = '0;
                    pend_set[i] = 1'b1;
                    state_d[i]  = ST_DONE;
                  end
                endcase
              end
            end
          end
          ST_DONE: begin
            en_d[i]    = 1'b0;
            state_d[i] = ST_IDLE;
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end

      // A new preset is only picked up at the next LOAD or reload.
      if (preset_wr[i]) begin
        preset_d[i] = datain[WIDTH-1:0];
      end
    end

    pending_d = pend_set | (pending_q & ~status_clr);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        preset_q[i] <= '0;
        mode_q[i]   <= '0;
      end
      en_q      <= '0;
      im_q      <= '0;
      tout_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        preset_q[i] <= preset_d[i];
        mode_q[i]   <= mode_d[i];
      end
      en_q      <= en_d;
      im_q      <= im_d;
      tout_q    <= tout_d;
      pending_q <= pending_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (ch_valid) begin
      case (addr_reg)
        REG_CTRL: begin
          rd_data[0]   = en_q[addr_ch];
          rd_data[2:1] = mode_q[addr_ch];
          rd_data[3]   = im_q[addr_ch];
        end
        REG_PRESET: rd_data[WIDTH-1:0]  = preset_q[addr_ch];
        REG_COUNT:  rd_data[WIDTH-1:0]  = count_q[addr_ch];
        default:    rd_data[NUM_CH-1:0] = pending_q;
      endcase
    end
  end

  assign dataout = rd_data;

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign irq     = pending_q & im_q;
  assign irq_any = |irq;
  assign tout    = tout_q;

  // Write data bits that no register stores.
  logic unused_datain;
  assign unused_datain = ^datain;

endmodule

// File: tb/tb_timer_array.sv
// ---------------------------------------------------------------------------
// tb_timer_array
//
// Directed self-checking bench for timer_array with default parameters
// (2 channels, 32-bit counters, no prescaler). Inputs change 1 ns after the
// rising edge. Reads and output checks happen before the next edge.
// ---------------------------------------------------------------------------
module tb_timer_array;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 32;
  localparam int AW     = $clog2(NUM_CH) + 2;

  // Channel 0 / channel 1 register addresses
  localparam logic [AW-1:0] CTRL0   = 3'd0;
  localparam logic [AW-1:0] PRESET0 = 3'd1;
  localparam logic [AW-1:0] COUNT0  = 3'd2;
  localparam logic [AW-1:0] STATUS0 = 3'd3;
  localparam logic [AW-1:0] CTRL1   = 3'd4;
  localparam logic [AW-1:0] PRESET1 = 3'd5;
  localparam logic [AW-1:0] COUNT1  = 3'd6;
  localparam logic [AW-1:0] STATUS1 = 3'd7;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     addr;
  logic              we;
  logic [31:0]       datain;
  logic [31:0]       dataout;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  logic [NUM_CH-1:0] tout;

  int testCount = 0;
  int failCount = 0;

  timer_array #(
    .NUM_CH  (NUM_CH),
    .WIDTH   (WIDTH),
    .PRESCALE(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .datain (datain),
    .dataout(dataout),
    .irq    (irq),
    .irq_any(irq_any),
    .tout   (tout)
  );

  // 20 ns clock leaves room for several 1 ns read settles per cycle
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h",
               tag, observed, expected);
    end
  endtask

  // Advances n rising edges and lands 1 ns after the last one
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus write, captured on the next rising edge
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    datain = '0;
  endtask

  task automatic checkReg(input string tag, input logic [AW-1:0] a,
                          input logic [31:0] expected);
    addr = a;
    #1;
    checkOutput(tag, dataout, expected);
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    addr   = '0;
    datain = '0;
    stepCycles(3);
    reset = 1'b0;

    // Reset state
    checkReg("rst_ctrl0", CTRL0, 32'h0);
    checkReg("rst_preset0", PRESET0, 32'h0);
    checkReg("rst_count0", COUNT0, 32'h0);
    checkReg("rst_ctrl1", CTRL1, 32'h0);
    checkReg("rst_count1", COUNT1, 32'h0);
    checkReg("rst_status", STATUS1, 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_irq_any", 32'(irq_any), 32'h0);
    checkOutput("rst_tout", 32'(tout), 32'h0);

    // One-shot on channel 0, preset 5, enable written at edge t
    applyStimulus(PRESET0, 32'd5);
    applyStimulus(CTRL0, 32'h9);
    checkReg("os_count_load", COUNT0, 32'd0);
    stepCycles(1);
    checkReg("os_count_t1", COUNT0, 32'd5);
    stepCycles(4);
    checkReg("os_count_t5", COUNT0, 32'd1);
    checkOutput("os_irq_t5", 32'(irq), 32'h0);
    stepCycles(1);
    checkOutput("os_irq_t6", 32'(irq), 32'h1);
    checkOutput("os_irq_any_t6", 32'(irq_any), 32'h1);
    checkReg("os_count_t6", COUNT0, 32'd0);
    checkReg("os_ctrl_t6", CTRL0, 32'h9);
    stepCycles(1);
    checkReg("os_ctrl_t7", CTRL0, 32'h8);
    applyStimulus(STATUS0, 32'h1);
    checkOutput("os_irq_cleared", 32'(irq), 32'h0);
    checkReg("os_status_cleared", STATUS0, 32'h0);

    // Periodic on channel 1, preset 3, expiries at t+4, t+7, t+10
    applyStimulus(PRESET1, 32'd3);
    applyStimulus(CTRL1, 32'hB);
    stepCycles(3);
    checkReg("per_status_t3", STATUS1, 32'h0);
    checkReg("per_count_t3", COUNT1, 32'd1);
    stepCycles(1);
    checkReg("per_status_t4", STATUS1, 32'h2);
    checkOutput("per_irq_t4", 32'(irq), 32'h2);
    checkReg("per_count_t4", COUNT1, 32'd3);
    applyStimulus(STATUS1, 32'h2);
    checkReg("per_status_t5", STATUS1, 32'h0);
    stepCycles(1);
    checkReg("per_status_t6", STATUS1, 32'h0);
    stepCycles(1);
    checkReg("per_status_t7", STATUS1, 32'h2);
    stepCycles(2);
    applyStimulus(STATUS1, 32'h2);
    checkReg("per_set_wins", STATUS1, 32'h2);
    applyStimulus(STATUS1, 32'h2);
    checkReg("per_clear_t11", STATUS1, 32'h0);
    applyStimulus(CTRL1, 32'h0);
    checkReg("per_stopped_ctrl", CTRL1, 32'h0);

    // Square wave on channel 0, preset 4, first toggle at t+5
    applyStimulus(PRESET0, 32'd4);
    applyStimulus(CTRL0, 32'h5);
    stepCycles(4);
    checkOutput("sq_tout_t4", 32'(tout), 32'h0);
    stepCycles(1);
    checkOutput("sq_tout_t5", 32'(tout), 32'h1);
    checkReg("sq_count_t5", COUNT0, 32'd4);
    checkOutput("sq_irq", 32'(irq), 32'h0);
    checkReg("sq_status", STATUS0, 32'h0);
    stepCycles(1);
    applyStimulus(CTRL0, 32'h4);
    checkReg("sq_freeze_count", COUNT0, 32'd3);
    checkOutput("sq_freeze_tout", 32'(tout), 32'h1);
    checkReg("sq_freeze_ctrl", CTRL0, 32'h4);
    stepCycles(6);
    checkReg("sq_held_count", COUNT0, 32'd3);
    checkOutput("sq_held_tout", 32'(tout), 32'h1);

    // Masked one-shot on channel 1, then unmask
    applyStimulus(PRESET1, 32'd2);
    applyStimulus(CTRL1, 32'h1);
    stepCycles(2);
    checkReg("mask_status_t2", STATUS1, 32'h0);
    stepCycles(1);
    checkReg("mask_status_t3", STATUS1, 32'h2);
    checkOutput("mask_irq_t3", 32'(irq), 32'h0);
    checkOutput("mask_irq_any_t3", 32'(irq_any), 32'h0);
    stepCycles(1);
    checkReg("mask_ctrl_t4", CTRL1, 32'h0);
    applyStimulus(CTRL1, 32'h8);
    checkOutput("mask_irq_unmasked", 32'(irq), 32'h2);
    checkOutput("mask_irq_any_unmasked", 32'(irq_any), 32'h1);
    applyStimulus(STATUS1, 32'h2);
    checkOutput("mask_irq_cleared", 32'(irq), 32'h0);

    // Preset of zero behaves like one
    applyStimulus(PRESET1, 32'd0);
    applyStimulus(CTRL1, 32'h1);
    stepCycles(1);
    checkReg("p0_count_t1", COUNT1, 32'd1);
    stepCycles(1);
    checkReg("p0_status_t2", STATUS1, 32'h2);
    applyStimulus(STATUS1, 32'h2);

    // Preset rewrite mid-count on channel 0 (periodic, preset 3 then 6)
    applyStimulus(PRESET0, 32'd3);
    applyStimulus(CTRL0, 32'h3);
    stepCycles(4);
    checkReg("pr_status_t4", STATUS0, 32'h1);
    checkReg("pr_count_t4", COUNT0, 32'd3);
    applyStimulus(PRESET0, 32'd6);
    applyStimulus(STATUS0, 32'h1);
    checkReg("pr_status_t6", STATUS0, 32'h0);
    checkReg("pr_count_t6", COUNT0, 32'd1);
    stepCycles(1);
    checkReg("pr_status_t7", STATUS0, 32'h1);
    checkReg("pr_count_t7", COUNT0, 32'd6);
    applyStimulus(STATUS0, 32'h1);
    stepCycles(4);
    checkReg("pr_count_t12", COUNT0, 32'd1);
    checkReg("pr_status_t12", STATUS0, 32'h0);
    stepCycles(1);
    checkReg("pr_status_t13", STATUS0, 32'h1);
    checkReg("pr_count_t13", COUNT0, 32'd6);

    // Reset while channel 0 is counting with pending and tout set
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkReg("mr_ctrl0", CTRL0, 32'h0);
    checkReg("mr_preset0", PRESET0, 32'h0);
    checkReg("mr_count0", COUNT0, 32'h0);
    checkReg("mr_status", STATUS0, 32'h0);
    checkOutput("mr_tout", 32'(tout), 32'h0);
    checkOutput("mr_irq_any", 32'(irq_any), 32'h0);
    stepCycles(3);
    checkReg("mr_count0_idle", COUNT0, 32'h0);
    checkReg("mr_status_idle", STATUS0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
